ex_branch_target_reg: RTL and testbench

//  - EX-stage branch resolution, directly downstream of the left-shift-by-2 unit.
//  - Adds the shifted word offset to PC+4 and evaluates the branch condition from the ALU zero flag.
//  - Registers the result into a single-entry output stage with valid/ready handshake, feeding the EX/MEM / PC-select logic.

---
 rtl/ex_branch_target_reg_pkg.sv | 20 ++
 rtl/ex_branch_target_reg_if.sv | 31 +++
 rtl/ex_branch_target_reg_cond.sv | 22 ++
 rtl/ex_branch_target_reg.sv | 112 +++++++++++
 tb/tb_ex_branch_target_reg.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/ex_branch_target_reg_pkg.sv
// Shared EX-stage branch types: branch-op encoding, hold-stage states, default widths.
// Pure declarations, no logic.
package mips_ex_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int CNT_W_DEF  = 16;

  typedef enum logic [1:0] {
    BR_NONE = 2'b00,
    BR_BEQ  = 2'b01,
    BR_BNE  = 2'b10,
    BR_JMP  = 2'b11
  } br_type_t;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } hold_state_t;

endpackage

// File: rtl/ex_branch_target_reg_if.sv
// Branch-op input bus and registered branch-result bus.
// slave = the stage itself, master = its upstream/downstream environment.
interface ex_branch_target_reg_if #(
  parameter int ADDR_W = mips_ex_pkg::ADDR_W_DEF
);
  import mips_ex_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [ADDR_W-1:0] pc_plus4;
  logic [ADDR_W-1:0] shifted_offset;
  br_type_t          br_type;
  logic              alu_zero;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [ADDR_W-1:0] target_addr;
  logic              taken;
  logic              misaligned;

  modport slave (
    input  in_valid, pc_plus4, shifted_offset, br_type, alu_zero, flush, out_ready,
    output in_ready, out_valid, target_addr, taken, misaligned
  );

  modport master (
    output in_valid, pc_plus4, shifted_offset, br_type, alu_zero, flush, out_ready,
    input  in_ready, out_valid, target_addr, taken, misaligned
  );

endinterface

// File: rtl/ex_branch_target_reg_cond.sv
// Combinational branch decision from op type and ALU zero flag; zero latency.
// Shared with forwarding/hazard logic, so it carries no state and no handshake.
module branch_cond_eval
  import mips_ex_pkg::*;
(
  input  br_type_t br_type_i,
  input  logic     alu_zero_i,
  output logic     taken_o
);

  always_comb begin
    taken_o = 1'b0;
    case (br_type_i)
      BR_NONE: taken_o = 1'b0;
      BR_BEQ:  taken_o = alu_zero_i;
      BR_BNE:  taken_o = !alu_zero_i;
      BR_JMP:  taken_o = 1'b1;
      default: taken_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/ex_branch_target_reg.sv
// EX branch target add + condition, registered in a 1-deep valid/ready stage (1-cycle latency,
// full throughput; in_ready = !out_valid || out_ready). Optional counters under BRANCH_STATS_EN.
module ex_branch_target_reg
  import mips_ex_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
`ifdef BRANCH_STATS_EN
  , parameter int CNT_W = CNT_W_DEF
`endif
) (
  input  logic                  clock,
  input  logic                  reset,
  ex_branch_target_reg_if.slave bus
`ifdef BRANCH_STATS_EN
  , output logic [CNT_W-1:0]    taken_cnt,
  output logic [CNT_W-1:0]      not_taken_cnt
`endif
);

  hold_state_t       state_q, state_d;
  logic [ADDR_W-1:0] target_q, target_d;
  logic              taken_q, taken_d;
  logic              mis_q, mis_d;
  logic [ADDR_W-1:0] sum;
  logic              cond_taken;
  logic              accept;
  logic              load;

  branch_cond_eval u_cond (
    .br_type_i  (bus.br_type),
    .alu_zero_i (bus.alu_zero),
    .taken_o    (cond_taken)
  );

  // Carry out is discarded: targets wrap modulo 2^ADDR_W.
  assign sum          = bus.pc_plus4 + bus.shifted_offset;
  assign bus.in_ready = (state_q == ST_EMPTY) || bus.out_ready;
  assign accept       = bus.in_valid && bus.in_ready;
  assign load         = accept && !bus.flush;

  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    taken_d  = taken_q;
    mis_d    = mis_q;
    if (bus.flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: if (accept) state_d = ST_FULL;
        ST_FULL:  if (bus.out_ready && !accept) state_d = ST_EMPTY;
        default:  state_d = ST_EMPTY;
      endcase
    end
    if (load) begin
      target_d = sum;
      taken_d  = cond_taken;
      mis_d    = |sum[1:0];
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= ST_EMPTY;
      target_q <= '0;
      taken_q  <= 1'b0;
      mis_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      taken_q  <= taken_d;
      mis_q    <= mis_d;
    end
  end

  assign bus.out_valid   = (state_q == ST_FULL);
  assign bus.target_addr = target_q;
  assign bus.taken       = taken_q;
  assign bus.misaligned  = mis_q;

`ifdef BRANCH_STATS_EN
  logic [CNT_W-1:0] tcnt_q, tcnt_d;
  logic [CNT_W-1:0] ntcnt_q, ntcnt_d;
  logic             count;

  // Counted at accept, so an op flushed in the same or a later cycle still counts.
  assign count = accept && (bus.br_type != BR_NONE);

  always_comb begin
    tcnt_d  = tcnt_q;
    ntcnt_d = ntcnt_q;
    if (count && cond_taken && !(&tcnt_q))
      tcnt_d = tcnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    if (count && !cond_taken && !(&ntcnt_q))
      ntcnt_d = ntcnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tcnt_q  <= '0;
      ntcnt_q <= '0;
    end else begin
      tcnt_q  <= tcnt_d;
      ntcnt_q <= ntcnt_d;
    end
  end

  assign taken_cnt     = tcnt_q;
  assign not_taken_cnt = ntcnt_q;
`endif

endmodule

// File: tb/tb_ex_branch_target_reg.sv
// Directed bench for ex_branch_target_reg: hand-computed targets/decisions, handshake, flush, reset.
// Counter checks are compiled in when BRANCH_STATS_EN is defined.
module tb_ex_branch_target_reg;
  import mips_ex_pkg::*;

  logic clock;
  logic reset;
  int   tests;
  int   fails;

  ex_branch_target_reg_if #(.ADDR_W(32)) bus ();

`ifdef BRANCH_STATS_EN
  logic [3:0] taken_cnt;
  logic [3:0] not_taken_cnt;
`endif

  ex_branch_target_reg #(
    .ADDR_W(32)
`ifdef BRANCH_STATS_EN
    , .CNT_W(4)
`endif
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
`ifdef BRANCH_STATS_EN
    , .taken_cnt     (taken_cnt),
    .not_taken_cnt (not_taken_cnt)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic vld, input br_type_t bt, input logic [31:0] pc,
                       input logic [31:0] off, input logic z);
    bus.in_valid       = vld;
    bus.br_type        = bt;
    bus.pc_plus4       = pc;
    bus.shifted_offset = off;
    bus.alu_zero       = z;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    reset = 1'b1;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b0;
    drive(1'b0, BR_NONE, 32'h0, 32'h0, 1'b0);

    // Reset state
    #3;
    chk("rst_out_valid",  bus.out_valid, 0);
    chk("rst_target",     bus.target_addr, 0);
    chk("rst_taken",      bus.taken, 0);
    chk("rst_misaligned", bus.misaligned, 0);
    chk("rst_in_ready",   bus.in_ready, 1);
`ifdef BRANCH_STATS_EN
    chk("rst_taken_cnt",  taken_cnt, 0);
    chk("rst_nt_cnt",     not_taken_cnt, 0);
`endif
    #9 reset = 1'b0;
    tick();

    // BEQ taken
    bus.out_ready = 1'b1;
    drive(1'b1, BR_BEQ, 32'h0040_0004, 32'h0000_0010, 1'b1);
    tick();
    chk("beq_valid",  bus.out_valid, 1);
    chk("beq_target", bus.target_addr, 32'h0040_0014);
    chk("beq_taken",  bus.taken, 1);
    chk("beq_mis",    bus.misaligned, 0);

    // BNE with zero=1, negative offset to address 0 (back-to-back)
    drive(1'b1, BR_BNE, 32'h0000_0008, 32'hFFFF_FFF8, 1'b1);
    tick();
    chk("bne_valid",  bus.out_valid, 1);
    chk("bne_target", bus.target_addr, 32'h0000_0000);
    chk("bne_taken",  bus.taken, 0);

    // NONE with an unaligned pc_plus4 -> misaligned target
    drive(1'b1, BR_NONE, 32'h0000_0101, 32'h0000_0004, 1'b1);
    tick();
    chk("none_target", bus.target_addr, 32'h0000_0105);
    chk("none_taken",  bus.taken, 0);
    chk("none_mis",    bus.misaligned, 1);

    // JMP with wrapping add
    drive(1'b1, BR_JMP, 32'hFFFF_FFFC, 32'h0000_0008, 1'b0);
    tick();
    chk("wrap_target", bus.target_addr, 32'h0000_0004);
    chk("wrap_taken",  bus.taken, 1);
    chk("wrap_mis",    bus.misaligned, 0);

    // Backpressure for 3 cycles: held result must not change
    bus.out_ready = 1'b0;
    drive(1'b1, BR_BEQ, 32'h0000_1000, 32'h0000_0020, 1'b0);
    #1;
    chk("hold_in_ready", bus.in_ready, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("hold_valid",  bus.out_valid, 1);
      chk("hold_target", bus.target_addr, 32'h0000_0004);
      chk("hold_taken",  bus.taken, 1);
      chk("hold_in_ready_cyc", bus.in_ready, 0);
    end
    bus.out_ready = 1'b1;
    #1;
    chk("release_in_ready", bus.in_ready, 1);
    tick();
    chk("rel_valid",  bus.out_valid, 1);
    chk("rel_target", bus.target_addr, 32'h0000_1020);
    chk("rel_taken",  bus.taken, 0);
    drive(1'b1, BR_BNE, 32'h0000_2000, 32'h0000_0040, 1'b0);
    tick();
    chk("b2b_valid",  bus.out_valid, 1);
    chk("b2b_target", bus.target_addr, 32'h0000_2040);
    chk("b2b_taken",  bus.taken, 1);
    drive(1'b0, BR_NONE, 32'h0, 32'h0, 1'b0);
    tick();
    chk("drain_valid",    bus.out_valid, 0);
    chk("drain_in_ready", bus.in_ready, 1);

    // Flush with in_valid while FULL: result killed, input dropped
    bus.out_ready = 1'b0;
    drive(1'b1, BR_BEQ, 32'h0000_3000, 32'h0000_0008, 1'b1);
    tick();
    chk("fl_load_valid",  bus.out_valid, 1);
    chk("fl_load_target", bus.target_addr, 32'h0000_3008);
    bus.out_ready = 1'b1;
    bus.flush     = 1'b1;
    drive(1'b1, BR_JMP, 32'h0000_5000, 32'h0000_0010, 1'b0);
    tick();
    chk("flush_valid", bus.out_valid, 0);
    bus.flush = 1'b0;
    drive(1'b0, BR_NONE, 32'h0, 32'h0, 1'b0);
    tick();
    chk("flush_dropped", bus.out_valid, 0);

    // Asynchronous reset mid-cycle while FULL
    bus.out_ready = 1'b0;
    drive(1'b1, BR_JMP, 32'h0000_7000, 32'h0000_0100, 1'b0);
    tick();
    chk("pre_rst_valid",  bus.out_valid, 1);
    chk("pre_rst_target", bus.target_addr, 32'h0000_7100);
    drive(1'b0, BR_NONE, 32'h0, 32'h0, 1'b0);
    #2 reset = 1'b1;
    #1;
    chk("arst_valid",  bus.out_valid, 0);
    chk("arst_target", bus.target_addr, 0);
    chk("arst_taken",  bus.taken, 0);
    #3 reset = 1'b0;
    tick();

`ifdef BRANCH_STATS_EN
    // 5 taken, 3 not-taken, 2 NONE, all accepted back-to-back
    bus.out_ready = 1'b1;
    chk("st_taken_cnt0", taken_cnt, 0);
    drive(1'b1, BR_JMP, 32'h100, 32'h4, 1'b0); tick();
    drive(1'b1, BR_BEQ, 32'h100, 32'h4, 1'b1); tick();
    drive(1'b1, BR_BNE, 32'h100, 32'h4, 1'b0); tick();
    drive(1'b1, BR_BEQ, 32'h100, 32'h4, 1'b0); tick();
    drive(1'b1, BR_NONE, 32'h100, 32'h4, 1'b1); tick();
    drive(1'b1, BR_JMP, 32'h100, 32'h4, 1'b1); tick();
    drive(1'b1, BR_BNE, 32'h100, 32'h4, 1'b1); tick();
    drive(1'b1, BR_BEQ, 32'h100, 32'h4, 1'b1); tick();
    drive(1'b1, BR_NONE, 32'h100, 32'h4, 1'b0); tick();
    drive(1'b1, BR_BNE, 32'h100, 32'h4, 1'b1); tick();
    drive(1'b0, BR_NONE, 32'h0, 32'h0, 1'b0); tick();
    chk("st_taken_cnt", taken_cnt, 5);
    chk("st_nt_cnt",    not_taken_cnt, 3);
    // 12 more taken on a 4-bit counter: 17 saturates at 15
    for (int i = 0; i < 12; i++) begin
      drive(1'b1, BR_JMP, 32'h200, 32'h8, 1'b0);
      tick();
    end
    drive(1'b0, BR_NONE, 32'h0, 32'h0, 1'b0);
    tick();
    chk("st_taken_sat", taken_cnt, 15);
    chk("st_nt_hold",   not_taken_cnt, 3);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
